// File: rtl/ycc_pkg.sv
// ycc_pkg: shared constants and pixel types for the YCbCr <-> RGB converters.
// Coefficients are x256 fixed point; sums are carried at ACC_W signed bits.
package ycc_pkg;

    // Inverse-transform coefficient defaults (x256 scale)
    localparam int COEF_R_CR_DEF = 359;  // 1.402
    localparam int COEF_G_CB_DEF = 88;   // 0.344
    localparam int COEF_G_CR_DEF = 183;  // 0.714
    localparam int COEF_B_CB_DEF = 454;  // 1.772

    localparam int CHROMA_OFFSET = 128;
    localparam int FRAC_BITS     = 8;
    localparam int ROUND         = 128;
    localparam int ACC_W         = 19;

    typedef struct packed {
        logic [7:0] y;
        logic [7:0] cb;
        logic [7:0] cr;
    } ycc_pix_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_pix_t;

endpackage

// File: rtl/ycbcr_to_rgb_if.sv
// ycbcr_to_rgb_if: valid/ready pixel bus for the YCbCr -> RGB converter.
// slave = converter view, master = source/sink view.
// Optional: YCC2RGB_CLIP_FLAG_EN adds clip_flags {R,G,B}.
interface ycbcr_to_rgb_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] luma_ch;
    logic [7:0] cb_ch;
    logic [7:0] cr_ch;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] red_ch;
    logic [7:0] green_ch;
    logic [7:0] blue_ch;
`ifdef YCC2RGB_CLIP_FLAG_EN
    logic [2:0] clip_flags;
`endif

    modport slave (
        input  in_valid, luma_ch, cb_ch, cr_ch, out_ready,
        output in_ready, out_valid, red_ch, green_ch, blue_ch
`ifdef YCC2RGB_CLIP_FLAG_EN
        , output clip_flags
`endif
    );

    modport master (
        output in_valid, luma_ch, cb_ch, cr_ch, out_ready,
        input  in_ready, out_valid, red_ch, green_ch, blue_ch
`ifdef YCC2RGB_CLIP_FLAG_EN
        , input clip_flags
`endif
    );
endinterface

// File: rtl/ycc_clamp_u8.sv
// ycc_clamp_u8: round, drop the fraction bits and saturate a signed
// fixed-point sum to an unsigned 8-bit channel.
// Optional: YCC2RGB_CLIP_FLAG_EN adds the clip output.
module ycc_clamp_u8
    import ycc_pkg::*;
(
    input  logic signed [ACC_W-1:0] acc,
    output logic        [7:0]       pix
`ifdef YCC2RGB_CLIP_FLAG_EN
    ,
    output logic                    clip
`endif
);
    localparam int WHOLE_W = ACC_W - FRAC_BITS;

    logic signed [ACC_W-1:0]   rounded;
    logic signed [WHOLE_W-1:0] whole;
    logic                      neg;
    logic                      over;

    assign rounded = acc + ACC_W'(ROUND);
    assign whole   = WHOLE_W'(rounded >>> FRAC_BITS);
    assign neg     = whole[WHOLE_W-1];
    assign over    = !neg && (|whole[WHOLE_W-2:8]);

    // Saturate to 0..255
    // NOTE: pix gets a default before the branches so no latch is inferred.
    always_comb begin
        pix = whole[7:0];
        if (neg) begin
            pix = '0;
        end else if (over) begin
            pix = '1;
        end
    end

`ifdef YCC2RGB_CLIP_FLAG_EN
    assign clip = neg || over;
`endif

endmodule

// File: rtl/ycbcr_to_rgb.sv
// ycbcr_to_rgb: 3-stage full-range YCbCr -> RGB converter with valid/ready
// on both sides. S1 removes the chroma offset, S2 forms the products, S3
// sums, rounds and clamps into the registered outputs.
// Optional: define YCC2RGB_CLIP_FLAG_EN for per-channel clip_flags.
module ycbcr_to_rgb
    import ycc_pkg::*;
#(
    parameter int COEF_R_CR = COEF_R_CR_DEF,
    parameter int COEF_G_CB = COEF_G_CB_DEF,
    parameter int COEF_G_CR = COEF_G_CR_DEF,
    parameter int COEF_B_CB = COEF_B_CB_DEF
) (
    input logic           clk,
    input logic           rst,
    ycbcr_to_rgb_if.slave bus
);
    localparam logic signed [ACC_W-1:0] K_R_CR = ACC_W'(COEF_R_CR);
    localparam logic signed [ACC_W-1:0] K_G_CB = ACC_W'(COEF_G_CB);
    localparam logic signed [ACC_W-1:0] K_G_CR = ACC_W'(COEF_G_CR);
    localparam logic signed [ACC_W-1:0] K_B_CB = ACC_W'(COEF_B_CB);

    // Stage occupancy and advance
    logic v1, v2, v3;
    logic adv1, adv2, adv3;

    ycc_pix_t in_pix;

    // S1 registers
    logic [7:0]        s1_y;
    logic signed [8:0] s1_dcb;
    logic signed [8:0] s1_dcr;

    // S2 registers
    logic [7:0]              s2_y;
    logic signed [ACC_W-1:0] s2_r_cr;
    logic signed [ACC_W-1:0] s2_g_cb;
    logic signed [ACC_W-1:0] s2_g_cr;
    logic signed [ACC_W-1:0] s2_b_cb;

    // S3 combinational sums and clamped channels
    logic signed [ACC_W-1:0] y_sh;
    logic signed [ACC_W-1:0] sum_r, sum_g, sum_b;
    logic [7:0]              r_d, g_d, b_d;
    rgb_pix_t                rgb_q;
`ifdef YCC2RGB_CLIP_FLAG_EN
    logic [2:0]              clip_d;
    logic [2:0]              clip_q;
`endif

    // A stage moves when it is empty or its successor moves
    assign adv3 = !v3 || bus.out_ready;
    assign adv2 = !v2 || adv3;
    assign adv1 = !v1 || adv2;

    assign bus.in_ready  = adv1;
    assign bus.out_valid = v3;

    assign in_pix = '{y: bus.luma_ch, cb: bus.cb_ch, cr: bus.cr_ch};

    // Per-stage valid bits
    // NOTE: state registers use non-blocking assignments so every stage
    // samples its predecessor's value from before the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
        end else begin
            if (adv1) v1 <= bus.in_valid;
            if (adv2) v2 <= v1;
            if (adv3) v3 <= v2;
        end
    end

    // S1/S2 datapath: offset removal, then coefficient products
    // NOTE: internal pipeline data carries no reset; the valid bits
    // qualify it, and only the visible outputs must read zero after reset.
    always_ff @(posedge clk) begin
        if (adv1 && bus.in_valid) begin
            s1_y   <= in_pix.y;
            s1_dcb <= $signed({1'b0, in_pix.cb}) - 9'(CHROMA_OFFSET);
            s1_dcr <= $signed({1'b0, in_pix.cr}) - 9'(CHROMA_OFFSET);
        end
        if (adv2 && v1) begin
            s2_y    <= s1_y;
            s2_r_cr <= ACC_W'(s1_dcr) * K_R_CR;
            s2_g_cb <= ACC_W'(s1_dcb) * K_G_CB;
            s2_g_cr <= ACC_W'(s1_dcr) * K_G_CR;
            s2_b_cb <= ACC_W'(s1_dcb) * K_B_CB;
        end
    end

    assign y_sh  = $signed({{(ACC_W-8-FRAC_BITS){1'b0}}, s2_y, {FRAC_BITS{1'b0}}});
    assign sum_r = y_sh + s2_r_cr;
    assign sum_g = y_sh - s2_g_cb - s2_g_cr;
    assign sum_b = y_sh + s2_b_cb;

    ycc_clamp_u8 u_clamp_r (
        .acc  (sum_r),
        .pix  (r_d)
`ifdef YCC2RGB_CLIP_FLAG_EN
        ,
        .clip (clip_d[2])
`endif
    );

    ycc_clamp_u8 u_clamp_g (
        .acc  (sum_g),
        .pix  (g_d)
`ifdef YCC2RGB_CLIP_FLAG_EN
        ,
        .clip (clip_d[1])
`endif
    );

    ycc_clamp_u8 u_clamp_b (
        .acc  (sum_b),
        .pix  (b_d)
`ifdef YCC2RGB_CLIP_FLAG_EN
        ,
        .clip (clip_d[0])
`endif
    );

    // S3 output registers, held while the sink stalls
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rgb_q <= '0;
`ifdef YCC2RGB_CLIP_FLAG_EN
            clip_q <= '0;
`endif
        end else if (adv3 && v2) begin
            rgb_q <= '{r: r_d, g: g_d, b: b_d};
`ifdef YCC2RGB_CLIP_FLAG_EN
            clip_q <= clip_d;
`endif
        end
    end

    assign bus.red_ch   = rgb_q.r;
    assign bus.green_ch = rgb_q.g;
    assign bus.blue_ch  = rgb_q.b;
`ifdef YCC2RGB_CLIP_FLAG_EN
    assign bus.clip_flags = clip_q;
`endif

endmodule

// File: tb/tb_ycbcr_to_rgb.sv
// tb_ycbcr_to_rgb: directed vectors, backpressure, throughput, random
// streaming and mid-stream reset for ycbcr_to_rgb.
// Honours YCC2RGB_CLIP_FLAG_EN when comparing clip flags.
module tb_ycbcr_to_rgb;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    ycbcr_to_rgb_if bus ();

    ycbcr_to_rgb dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [7:0] y;
        logic [7:0] cb;
        logic [7:0] cr;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic [2:0] fl;
    } vec_t;

`ifdef YCC2RGB_CLIP_FLAG_EN
    localparam logic [26:0] MASK = 27'h7FF_FFFF;
`else
    localparam logic [26:0] MASK = 27'h0FF_FFFF;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [23:0] send_q[$];
    logic [26:0] recv_q[$];
    int          send_idx;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Integer reference: returns {clip R,G,B, r, g, b}
    function automatic logic [26:0] model(input logic [23:0] ycc);
        int         y, dcb, dcr, q;
        int         acc[3];
        logic [7:0] c[3];
        logic [2:0] f;
        y   = int'(ycc[23:16]);
        dcb = int'(ycc[15:8]) - 128;
        dcr = int'(ycc[7:0]) - 128;
        acc[0] = y * 256 + 359 * dcr + 128;
        acc[1] = y * 256 - 88 * dcb - 183 * dcr + 128;
        acc[2] = y * 256 + 454 * dcb + 128;
        for (int i = 0; i < 3; i++) begin
            q = acc[i] >>> 8;
            if (q < 0) begin
                c[i] = 8'd0;   f[2-i] = 1'b1;
            end else if (q > 255) begin
                c[i] = 8'd255; f[2-i] = 1'b1;
            end else begin
                c[i] = q[7:0]; f[2-i] = 1'b0;
            end
        end
        return {f, c[0], c[1], c[2]};
    endfunction

    function automatic logic [26:0] sample_out();
        logic [2:0] f = 3'b000;
`ifdef YCC2RGB_CLIP_FLAG_EN
        f = bus.clip_flags;
`endif
        return {f, bus.red_ch, bus.green_ch, bus.blue_ch};
    endfunction

    // One cycle of stream traffic; transfers are decided from values that
    // stay stable until the next rising edge.
    task automatic step(input bit want_valid, input bit rdy);
        @(negedge clk);
        bus.out_ready = rdy;
        if (want_valid && send_idx < send_q.size()) begin
            bus.in_valid = 1'b1;
            {bus.luma_ch, bus.cb_ch, bus.cr_ch} = send_q[send_idx];
        end else begin
            bus.in_valid = 1'b0;
        end
        #1;
        if (bus.in_valid && bus.in_ready) send_idx++;
        if (bus.out_valid && bus.out_ready) recv_q.push_back(sample_out());
    endtask

    // Single pixel into an empty pipe; lat counts edges from accept to out_valid
    task automatic push_one(input logic [23:0] ycc, output logic [26:0] got, output int lat);
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        {bus.luma_ch, bus.cb_ch, bus.cr_ch} = ycc;
        #1;
        check("push_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        got = sample_out();
    endtask

    task automatic compare_stream(input string tag);
        check($sformatf("%s_count", tag), 32'(recv_q.size()), 32'(send_q.size()));
        for (int i = 0; i < recv_q.size() && i < send_q.size(); i++)
            check($sformatf("%s_pix%0d", tag, i), 32'(recv_q[i] & MASK), 32'(model(send_q[i]) & MASK));
    endtask

    task automatic reset_queues();
        send_q.delete();
        recv_q.delete();
        send_idx = 0;
    endtask

    initial begin
        vec_t        vecs[10];
        logic [26:0] got;
        logic [26:0] exp;
        int          lat;
        int          steps;

        bus.in_valid  = 1'b0;
        bus.luma_ch   = '0;
        bus.cb_ch     = '0;
        bus.cr_ch     = '0;
        bus.out_ready = 1'b0;
        send_idx      = 0;
        rst           = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_rgb", 32'(sample_out()), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("release_in_ready", 32'(bus.in_ready), 32'd1);
        check("release_out_valid", 32'(bus.out_valid), 32'd0);

        // Directed vectors: {Y, Cb, Cr} -> {R, G, B}, clip {R,G,B}
        vecs[0] = '{8'd128, 8'd128, 8'd128, 8'd128, 8'd128, 8'd128, 3'b000};
        vecs[1] = '{8'd255, 8'd128, 8'd255, 8'd255, 8'd164, 8'd255, 3'b100};
        vecs[2] = '{8'd0,   8'd128, 8'd0,   8'd0,   8'd92,  8'd0,   3'b100};
        vecs[3] = '{8'd0,   8'd128, 8'd128, 8'd0,   8'd0,   8'd0,   3'b000};
        vecs[4] = '{8'd255, 8'd128, 8'd128, 8'd255, 8'd255, 8'd255, 3'b000};
        vecs[5] = '{8'd128, 8'd255, 8'd128, 8'd128, 8'd84,  8'd255, 3'b001};
        vecs[6] = '{8'd128, 8'd0,   8'd128, 8'd128, 8'd172, 8'd0,   3'b001};
        vecs[7] = '{8'd0,   8'd0,   8'd0,   8'd0,   8'd136, 8'd0,   3'b101};
        vecs[8] = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd121, 8'd255, 3'b101};
        vecs[9] = '{8'd76,  8'd85,  8'd255, 8'd254, 8'd0,   8'd0,   3'b000};

        for (int i = 0; i < 10; i++) begin
            push_one({vecs[i].y, vecs[i].cb, vecs[i].cr}, got, lat);
            exp = {vecs[i].fl, vecs[i].r, vecs[i].g, vecs[i].b};
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
            check($sformatf("vec%0d_pixel", i), 32'(got & MASK), 32'(exp & MASK));
        end
        @(negedge clk);

        // Backpressure: sink stalled, five pixels offered
        reset_queues();
        send_q = '{24'h10_80_80, 24'h50_5A_F0, 24'hA0_30_20, 24'hEB_80_80, 24'h29_F0_6E};
        for (int c = 0; c < 8; c++) step(1'b1, 1'b0);
        check("bp_accepted", 32'(send_idx), 32'd3);
        check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
        check("bp_out_valid", 32'(bus.out_valid), 32'd1);
        check("bp_hold_early", 32'(sample_out() & MASK), 32'(model(send_q[0]) & MASK));
        for (int c = 0; c < 4; c++) step(1'b1, 1'b0);
        check("bp_hold_late", 32'(sample_out() & MASK), 32'(model(send_q[0]) & MASK));
        check("bp_out_valid_late", 32'(bus.out_valid), 32'd1);
        check("bp_none_emitted", 32'(recv_q.size()), 32'd0);
        steps = 0;
        while (recv_q.size() < 5 && steps < 50) begin
            step(1'b1, 1'b1);
            steps++;
        end
        compare_stream("bp");
        repeat (5) step(1'b0, 1'b1);

        // Throughput: both sides always ready
        reset_queues();
        for (int i = 0; i < 20; i++) send_q.push_back(24'((i * 24'h0B1D07) ^ 24'h5A3C96));
        steps = 0;
        while (recv_q.size() < 20 && steps < 100) begin
            step(1'b1, 1'b1);
            steps++;
        end
        check("tput_cycles", 32'(steps), 32'd23);
        compare_stream("tput");
        repeat (5) step(1'b0, 1'b1);

        // Random streaming with gaps on both sides
        reset_queues();
        for (int i = 0; i < 1000; i++) send_q.push_back(24'($urandom()));
        steps = 0;
        while (recv_q.size() < 1000 && steps < 20000) begin
            step($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 70);
            steps++;
        end
        compare_stream("rand");
        repeat (5) step(1'b0, 1'b1);

        // Reset with three pixels in flight
        reset_queues();
        send_q = '{24'h80_80_80, 24'h60_70_90, 24'hC0_A0_40};
        for (int c = 0; c < 4; c++) step(1'b1, 1'b0);
        check("rst_inflight", 32'(send_idx), 32'd3);
        check("rst_pre_valid", 32'(bus.out_valid), 32'd1);
        check("rst_pre_rgb", 32'(sample_out() & MASK), 32'(model(send_q[0]) & MASK));
        #1;
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check("rst_async_valid", 32'(bus.out_valid), 32'd0);
        check("rst_async_rgb", 32'(sample_out()), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        recv_q.delete();
        send_q.delete();
        send_idx = 0;
        for (int c = 0; c < 5; c++) step(1'b0, 1'b1);
        check("rst_no_stale", 32'(recv_q.size()), 32'd0);
        push_one(24'h40_C8_30, got, lat);
        check("rst_next_latency", 32'(lat), 32'd3);
        check("rst_next_pixel", 32'(got & MASK), 32'(model(24'h40_C8_30) & MASK));
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Guard against a stuck handshake
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
